// File: rtl/tl_pkg.sv
// Shared TileLink D-channel definitions for the xbar: opcodes, field widths,
// the beats-per-message helper and the demux FSM state type.
package tl_pkg;

    localparam int unsigned OPC_W  = 3;
    localparam int unsigned SIZE_W = 4;

    localparam logic [OPC_W-1:0] ACCESS_ACK      = 3'd0;
    localparam logic [OPC_W-1:0] ACCESS_ACK_DATA = 3'd1;
    localparam logic [OPC_W-1:0] GRANT           = 3'd4;
    localparam logic [OPC_W-1:0] GRANT_DATA      = 3'd5;
    localparam logic [OPC_W-1:0] RELEASE_ACK     = 3'd6;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } demux_state_e;

    // Beats in a message: data-carrying opcodes span 2^(size-beat_lg2) beats.
    function automatic logic [15:0] tl_beats(input logic [OPC_W-1:0]  opcode,
                                             input logic [SIZE_W-1:0] size,
                                             input int unsigned       beat_lg2);
        logic [15:0] n;
        n = 16'd1;
        if ((opcode == ACCESS_ACK_DATA || opcode == GRANT_DATA) && 32'(size) > beat_lg2) begin
            n = 16'd1 << (32'(size) - beat_lg2);
        end
        return n;
    endfunction

endpackage

// File: rtl/tl_pipe_reg.sv
// One-entry pipelined valid/ready register: accepts a new beat in the same
// cycle the held one leaves, so a stream runs at one beat per cycle.
module tl_pipe_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o
);

    logic         full_q;
    logic         full_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;
    logic         fire_in;

    always_comb begin
        ready_o = ~full_q | ready_i;
        fire_in = valid_i & ready_o;
        full_d  = fire_in | (full_q & ~ready_i);
        data_d  = fire_in ? data_i : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign valid_o = full_q;
    assign data_o  = data_q;

endmodule

// File: rtl/tl_demux.sv
// 1:N TileLink D-channel router: decodes the sink from the first beat of a
// message and keeps multi-beat messages locked to that sink until the last beat.
module tl_demux
    import tl_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned DATA_W   = 100,
    parameter int unsigned DEST_LSB = 0,
    parameter int unsigned OPC_LSB  = 97,
    parameter int unsigned SIZE_LSB = 93,
    parameter int unsigned BEAT_LG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_W-1:0]     data_i,
    output logic [N-1:0]          valid_o,
    input  logic [N-1:0]          ready_i,
    output logic [N*DATA_W-1:0]   data_o,
    output logic                  decode_err_o
);

    localparam int unsigned DEST_W = $clog2(N);
    localparam int unsigned CNT_W  = 16 - BEAT_LG2;

    logic                held_valid;
    logic [DATA_W-1:0]   held;
    logic                out_done;

    logic [DEST_W-1:0]   dest_fld;
    logic [DEST_W-1:0]   dest;
    logic [OPC_W-1:0]    opc;
    logic [SIZE_W-1:0]   size;
    logic                bad_fld;
    logic                bad_eff;
    logic                locked;
    logic                sel_ready;
    logic [CNT_W-1:0]    beats_first;

    demux_state_e        state_q, state_d;
    logic [DEST_W-1:0]   dest_q, dest_d;
    logic [CNT_W-1:0]    beats_left_q, beats_left_d;
    logic                drop_q, drop_d;
    logic                err_q, err_d;

    tl_pipe_reg #(.W(DATA_W)) u_in_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (held_valid),
        .ready_i (out_done),
        .data_o  (held)
    );

    // Route decode: first beat decodes its own field, followers reuse the lock.
    always_comb begin
        dest_fld    = held[DEST_LSB +: DEST_W];
        opc         = held[OPC_LSB +: OPC_W];
        size        = held[SIZE_LSB +: SIZE_W];
        bad_fld     = 32'(dest_fld) >= N;
        beats_first = CNT_W'(tl_beats(opc, size, BEAT_LG2));
        locked      = (state_q == ST_BURST);
        dest        = locked ? dest_q : dest_fld;
        bad_eff     = locked ? drop_q : bad_fld;

        valid_o   = '0;
        sel_ready = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (32'(dest) == k) begin
                valid_o[k] = held_valid & ~bad_eff;
                sel_ready  = ready_i[k];
            end
        end
        // Dropped beats drain without waiting on any sink.
        out_done = held_valid & (bad_eff | sel_ready);
    end

    always_comb begin
        state_d      = state_q;
        dest_d       = dest_q;
        beats_left_d = beats_left_q;
        drop_d       = drop_q;
        err_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (out_done) begin
                    err_d = bad_fld;
                    if (beats_first > CNT_W'(1)) begin
                        state_d      = ST_BURST;
                        dest_d       = dest_fld;
                        beats_left_d = beats_first - CNT_W'(1);
                        drop_d       = bad_fld;
                    end
                end
            end
            ST_BURST: begin
                if (out_done) begin
                    beats_left_d = beats_left_q - CNT_W'(1);
                    if (beats_left_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            dest_q       <= '0;
            beats_left_q <= '0;
            drop_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            dest_q       <= dest_d;
            beats_left_q <= beats_left_d;
            drop_q       <= drop_d;
            err_q        <= err_d;
        end
    end

    assign data_o       = {N{held}};
    assign decode_err_o = err_q;

endmodule

// File: tb/tb_tl_demux.sv
// Bench for tl_demux: an N=4 and an N=3 instance driven by directed vectors,
// checked every cycle against a message-level queue model.
module tb_tl_demux;
    import tl_pkg::*;

    localparam int unsigned DW = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic           v4_valid_i, v4_ready_o, v4_err;
    logic [DW-1:0]  v4_data_i;
    logic [3:0]     v4_valid_o, v4_ready_i;
    logic [4*DW-1:0] v4_data_o;

    logic           v3_valid_i, v3_ready_o, v3_err;
    logic [DW-1:0]  v3_data_i;
    logic [2:0]     v3_valid_o, v3_ready_i;
    logic [3*DW-1:0] v3_data_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    tl_demux #(.N(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .valid_i(v4_valid_i), .ready_o(v4_ready_o),
        .data_i(v4_data_i), .valid_o(v4_valid_o), .ready_i(v4_ready_i),
        .data_o(v4_data_o), .decode_err_o(v4_err)
    );

    tl_demux #(.N(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .valid_i(v3_valid_i), .ready_o(v3_ready_o),
        .data_i(v3_data_i), .valid_o(v3_valid_o), .ready_i(v3_ready_i),
        .data_o(v3_data_o), .decode_err_o(v3_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            lane;
        logic [DW-1:0] data;
        bit            drop;
        bit            first;
    } beat_t;

    // Model state per instance (0: N=4, 1: N=3)
    beat_t infl[2][$];
    int    rem[2];
    int    cur_lane[2];
    bit    cur_drop[2];
    bit    err_pend[2];
    int    lane_cnt[2][16];
    int    err_cnt[2];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] msg(input logic [2:0] opc, input logic [3:0] sz,
                                          input logic [1:0] dst, input logic [23:0] tag);
        logic [DW-1:0] m;
        m = '0;
        m[99:97] = opc;
        m[96:93] = sz;
        m[31:8]  = tag;
        m[1:0]   = dst;
        return m;
    endfunction

    task automatic model_step(input int d, input int n, input logic vi, input logic [DW-1:0] di,
                              input logic ro, input logic [15:0] vo, input logic [15:0] ri,
                              input logic [16*DW-1:0] dout, input logic err);
        beat_t b;
        logic [15:0] ev;
        bit leave, exp_ro;
        int dst, opc, sz, beats;
        ev = '0;
        leave = 0;
        if (infl[d].size() > 0) begin
            b = infl[d][0];
            if (!b.drop) ev = 16'(1) << b.lane;
            leave = b.drop || (ri[b.lane] == 1'b1);
        end
        chk($sformatf("valid_o[%0d]", d), 128'(vo), 128'(ev));
        if (ev != 0 && vo === ev)
            chk($sformatf("data_o[%0d]", d), 128'(dout[b.lane*DW +: DW]), 128'(b.data));
        exp_ro = (infl[d].size() == 0) || leave;
        chk($sformatf("ready_o[%0d]", d), 128'(ro), 128'(exp_ro));
        chk($sformatf("decode_err[%0d]", d), 128'(err), 128'(err_pend[d]));
        if (err) err_cnt[d]++;
        err_pend[d] = 0;
        if (leave) begin
            err_pend[d] = b.drop && b.first;
            if (!b.drop) lane_cnt[d][b.lane]++;
            void'(infl[d].pop_front());
        end
        if (vi && exp_ro) begin
            b.data = di;
            if (rem[d] == 0) begin
                dst = int'(di[1:0]) & ((1 << $clog2(n)) - 1);
                opc = int'(di[99:97]);
                sz  = int'(di[96:93]);
                beats = ((opc == 1 || opc == 5) && sz > 3) ? (1 << (sz - 3)) : 1;
                cur_lane[d] = dst;
                cur_drop[d] = (dst >= n);
                rem[d]      = beats - 1;
                b.first     = 1;
            end else begin
                rem[d]--;
                b.first = 0;
            end
            b.lane = cur_lane[d];
            b.drop = cur_drop[d];
            infl[d].push_back(b);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                infl[d].delete();
                rem[d] = 0;
                err_pend[d] = 0;
            end
            chk("rst_valid4", 128'(v4_valid_o), 128'(0));
            chk("rst_ready4", 128'(v4_ready_o), 128'(1));
            chk("rst_valid3", 128'(v3_valid_o), 128'(0));
        end else begin
            model_step(0, 4, v4_valid_i, v4_data_i, v4_ready_o, 16'(v4_valid_o), 16'(v4_ready_i),
                       (16*DW)'(v4_data_o), v4_err);
            model_step(1, 3, v3_valid_i, v3_data_i, v3_ready_o, 16'(v3_valid_o), 16'(v3_ready_i),
                       (16*DW)'(v3_data_o), v3_err);
        end
    end

    task automatic drive(input int d, input logic v, input logic [DW-1:0] dat);
        if (d == 0) begin v4_valid_i = v; v4_data_i = dat; end
        else        begin v3_valid_i = v; v3_data_i = dat; end
    endtask

    // Present one beat and return #1 after the edge that accepts it.
    task automatic send(input int d, input logic [DW-1:0] dat);
        int t;
        t = 0;
        drive(d, 1'b1, dat);
        @(negedge clk);
        while (((d == 0) ? v4_ready_o : v3_ready_o) !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout[%0d]: ready_o stuck low, required 1", d);
        end
        @(posedge clk);
        #1;
        drive(d, 1'b0, '0);
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        int base1, base3, c0;
        int b4[4];
        v4_valid_i = 0; v4_data_i = '0; v4_ready_i = 4'b1111;
        v3_valid_i = 0; v3_data_i = '0; v3_ready_i = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data_o", 128'(v4_data_o[DW-1:0]), 128'(0));
        chk("reset_err", 128'(v4_err), 128'(0));
        rst_n = 1'b1;
        idle(2);

        // Single-beat routing
        send(0, msg(ACCESS_ACK, 4'd0, 2'd2, 24'h100));
        chk("single_d2", 128'(v4_valid_o), 128'(4'b0100));
        send(0, msg(ACCESS_ACK, 4'd0, 2'd0, 24'h101));
        chk("single_d0", 128'(v4_valid_o), 128'(4'b0001));
        send(0, msg(ACCESS_ACK, 4'd0, 2'd3, 24'h102));
        chk("single_d3", 128'(v4_valid_o), 128'(4'b1000));
        chk("single_ready", 128'(v4_ready_o), 128'(1));
        idle(3);

        // Burst lock: 8-beat GrantData on lane 1, followers carry field 3;
        // non-selected sinks stall throughout.
        base1 = lane_cnt[0][1];
        base3 = lane_cnt[0][3];
        v4_ready_i = 4'b0010;
        send(0, msg(GRANT_DATA, 4'd6, 2'd1, 24'h200));
        for (int i = 1; i < 8; i++) begin
            send(0, msg(GRANT_DATA, 4'd6, 2'd3, 24'(32'h200 + i)));
            chk("burst_lane1", 128'(v4_valid_o), 128'(4'b0010));
        end
        idle(2);
        v4_ready_i = 4'b1111;
        send(0, msg(ACCESS_ACK, 4'd0, 2'd3, 24'h208));
        chk("post_burst_d3", 128'(v4_valid_o), 128'(4'b1000));
        idle(2);
        chk("burst_count", 128'(lane_cnt[0][1] - base1), 128'(8));
        chk("post_burst_count", 128'(lane_cnt[0][3] - base3), 128'(1));

        // Backpressure mid-burst
        base1 = lane_cnt[0][1];
        send(0, msg(GRANT_DATA, 4'd5, 2'd1, 24'h300));
        send(0, msg(GRANT_DATA, 4'd5, 2'd3, 24'h301));
        v4_ready_i[1] = 1'b0;
        fork
            send(0, msg(GRANT_DATA, 4'd5, 2'd3, 24'h302));
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_valid", 128'(v4_valid_o), 128'(4'b0010));
                    chk("bp_ready", 128'(v4_ready_o), 128'(0));
                    chk("bp_data", 128'(v4_data_o[DW +: DW]), 128'(msg(GRANT_DATA, 4'd5, 2'd3, 24'h301)));
                end
                @(posedge clk);
                #1;
                v4_ready_i[1] = 1'b1;
            end
        join
        send(0, msg(GRANT_DATA, 4'd5, 2'd3, 24'h303));
        idle(3);
        chk("bp_count", 128'(lane_cnt[0][1] - base1), 128'(4));

        // Throughput: 16 back-to-back single-beat messages
        for (int k = 0; k < 4; k++) b4[k] = lane_cnt[0][k];
        c0 = cyc;
        for (int i = 0; i < 16; i++)
            send(0, msg(ACCESS_ACK, 4'd0, 2'(i % 4), 24'(32'h400 + i)));
        chk("tput_cycles", 128'(cyc - c0), 128'(16));
        idle(2);
        for (int k = 0; k < 4; k++)
            chk($sformatf("tput_lane%0d", k), 128'(lane_cnt[0][k] - b4[k]), 128'(4));

        // Decode error on N=3: 2-beat AccessAckData to dest 3 is dropped
        send(1, msg(ACCESS_ACK_DATA, 4'd4, 2'd3, 24'h500));
        send(1, msg(ACCESS_ACK_DATA, 4'd4, 2'd0, 24'h501));
        send(1, msg(ACCESS_ACK, 4'd0, 2'd0, 24'h502));
        chk("derr_next_d0", 128'(v3_valid_o), 128'(3'b001));
        idle(3);
        chk("derr_pulses", 128'(err_cnt[1]), 128'(1));
        chk("derr_lane0", 128'(lane_cnt[1][0]), 128'(1));
        chk("derr_lane1", 128'(lane_cnt[1][1] + lane_cnt[1][2]), 128'(0));

        // Async reset in the middle of a 4-beat burst on lane 2
        send(0, msg(ACCESS_ACK_DATA, 4'd5, 2'd2, 24'h600));
        send(0, msg(ACCESS_ACK_DATA, 4'd5, 2'd2, 24'h601));
        v4_ready_i[2] = 1'b0;
        @(negedge clk);
        chk("pre_reset_valid", 128'(v4_valid_o), 128'(4'b0100));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 128'(v4_valid_o), 128'(0));
        chk("async_rst_ready", 128'(v4_ready_o), 128'(1));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        v4_ready_i = 4'b1111;
        idle(1);
        send(0, msg(ACCESS_ACK, 4'd0, 2'd3, 24'h602));
        chk("post_rst_unlocked", 128'(v4_valid_o), 128'(4'b1000));
        idle(3);

        chk("drain4", 128'(infl[0].size()), 128'(0));
        chk("drain3", 128'(infl[1].size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
